// File: rtl/rr_arbiter16.sv
// rr_arbiter16 - round-robin arbiter sharing one resource among 16 requesters.
//
// The winner is presented as a registered one-hot grant and as its 4-bit
// binary index. A hold timer withdraws the grant from an owner that has
// held it for MAX_HOLD cycles while at least one other requester waits.
// Every release is followed by at least one idle cycle before the next grant.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles when others are waiting (1..255)
// Ports:
//   clk       clock; all state updates on the rising edge
//   reset     synchronous, active-high reset
//   req       request lines; bit i high = requester i wants/keeps the resource
//   grant     one-hot grant, registered; zero when idle
//   grant_id  binary index of the bit set in grant; 0 when idle
//   busy      high whenever grant is non-zero
//   expire    one-cycle pulse on the cycle a grant is withdrawn by the timer
module rr_arbiter16 #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  output logic [15:0] grant,
  output logic [3:0]  grant_id,
  output logic        busy,
  output logic        expire
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t      state_reg, state_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic [15:0] grant_reg, grant_next;
  logic [3:0]  grant_id_reg, grant_id_next;
  logic        expire_reg, expire_next;

  // Candidate k is the index k+1 places after the last owner (mod 16), so
  // cand[15] wraps back to ptr itself and is examined last.
  logic [3:0] cand [16];
  logic [3:0] win;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cand
      assign cand[gi] = ptr_reg + 4'(gi + 1);
    end
  endgenerate

  // Scan from the furthest candidate down so the nearest requester wins.
  always_comb begin
    win = ptr_reg;
    for (int k = 15; k >= 0; k--) begin
      if (req[cand[k]]) win = cand[k];
    end
  end

  logic owner_req;
  logic others_pending;
  logic at_limit;
  logic forced;

  assign owner_req      = req[grant_id_reg];
  assign others_pending = |(req & ~grant_reg);
  assign at_limit       = (hold_cnt_reg == HOLD_LIMIT);
  // An owner that drops its request at the limit releases normally.
  assign forced         = owner_req && at_limit && others_pending;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 4'hF;
      hold_cnt_reg <= 8'd0;
      grant_reg    <= 16'h0000;
      grant_id_reg <= 4'h0;
      expire_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      expire_reg   <= expire_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next    = GRANT;
          hold_cnt_next = 8'd1;
        end
      end
      GRANT: begin
        if (!owner_req || forced) begin
          state_next    = IDLE;
          ptr_next      = grant_id_reg;
          hold_cnt_next = 8'd0;
        end else if (!at_limit) begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    grant_next    = 16'h0000;
    grant_id_next = 4'h0;
    expire_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          grant_next    = 16'd1 << win;
          grant_id_next = win;
        end
      end
      GRANT: begin
        if (owner_req && !forced) begin
          grant_next    = grant_reg;
          grant_id_next = grant_id_reg;
        end else begin
          expire_next = forced;
        end
      end
      default: begin
        grant_next = 16'h0000;
      end
    endcase
  end

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign busy     = |grant_reg;
  assign expire   = expire_reg;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Testbench for rr_arbiter16 (MAX_HOLD = 8): directed vectors feed a
// scoreboard queue; a monitor pops and compares one entry per clock and
// checks the grant invariants and waiting bound every cycle.
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req = 16'h0000;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        busy;
  logic        expire;

  always #5 clk = ~clk;

  rr_arbiter16 #(.MAX_HOLD(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .expire   (expire)
  );

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  id;
    logic        busy;
    logic        expire;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   wait_cnt [16];

  // Drive one cycle of stimulus and queue the outputs expected after the
  // next rising edge.
  task automatic step(input logic rst, input logic [15:0] r, input logic v,
                      input logic [3:0] id, input logic ex, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst;
    req   = r;
    e.grant  = v ? (16'd1 << id) : 16'h0000;
    e.id     = v ? id : 4'h0;
    e.busy   = v;
    e.expire = ex;
    e.name   = nm;
    sb_q.push_back(e);
  endtask

  function automatic logic [3:0] encode(input logic [15:0] g);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (g[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Monitor
  initial begin
    for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if ({grant, grant_id, busy, expire} !==
            {mon_e.grant, mon_e.id, mon_e.busy, mon_e.expire}) begin
          errors++;
          $display("FAIL %s: got grant=%h id=%0d busy=%b expire=%b, want grant=%h id=%0d busy=%b expire=%b",
                   mon_e.name, grant, grant_id, busy, expire,
                   mon_e.grant, mon_e.id, mon_e.busy, mon_e.expire);
        end else begin
          $display("ok   %s: grant=%h id=%0d busy=%b expire=%b",
                   mon_e.name, grant, grant_id, busy, expire);
        end
      end
      checks++;
      if ($isunknown({grant, grant_id, busy, expire}) ||
          ((grant & (grant - 16'd1)) != 16'h0000) ||
          (grant_id != encode(grant)) ||
          (busy != (|grant)) ||
          (expire && busy)) begin
        errors++;
        $display("FAIL invariant @%0t: grant=%h id=%0d busy=%b expire=%b, want one-hot grant, id=encode(grant), busy=|grant",
                 $time, grant, grant_id, busy, expire);
      end
      for (int i = 0; i < 16; i++) begin
        if (reset || !req[i] || grant[i]) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
      end
      checks++;
      for (int i = 0; i < 16; i++) begin
        if (wait_cnt[i] == 136) begin
          errors++;
          $display("FAIL wait_bound: requester %0d waited %0d cycles, limit 135", i, wait_cnt[i]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Reset and single request
    step(1, 16'h0000, 0, 0, 0, "reset_1");
    step(1, 16'h0000, 0, 0, 0, "reset_2");
    step(0, 16'h0020, 1, 5, 0, "single_grant");
    step(0, 16'h0000, 0, 0, 0, "single_release");
    step(0, 16'h0000, 0, 0, 0, "idle_stays");

    // Round-robin order 0, 8, 15, 0 from a reset pointer
    step(1, 16'h0000, 0, 0, 0, "rr_reset");
    step(0, 16'h8101, 1, 0,  0, "rr_g0_a");
    step(0, 16'h8101, 1, 0,  0, "rr_g0_b");
    step(0, 16'h8100, 0, 0,  0, "rr_gap0");
    step(0, 16'h8101, 1, 8,  0, "rr_g8_a");
    step(0, 16'h8101, 1, 8,  0, "rr_g8_b");
    step(0, 16'h8001, 0, 0,  0, "rr_gap8");
    step(0, 16'h8101, 1, 15, 0, "rr_g15_a");
    step(0, 16'h8101, 1, 15, 0, "rr_g15_b");
    step(0, 16'h0101, 0, 0,  0, "rr_gap15");
    step(0, 16'h8101, 1, 0,  0, "rr_g0_again");
    step(0, 16'h0000, 0, 0,  0, "rr_release");

    // Hold timeout with two contenders
    step(1, 16'h0000, 0, 0, 0, "hold_reset");
    for (int i = 0; i < 8; i++) step(0, 16'h0003, 1, 0, 0, "hold_g0");
    step(0, 16'h0003, 0, 0, 1, "hold_expire0");
    for (int i = 0; i < 8; i++) step(0, 16'h0003, 1, 1, 0, "hold_g1");
    step(0, 16'h0003, 0, 0, 1, "hold_expire1");
    for (int i = 0; i < 8; i++) step(0, 16'h0003, 1, 0, 0, "hold_g0_again");
    // Owner drops on the same cycle the limit is reached: normal release
    step(0, 16'h0002, 0, 0, 0, "drop_at_limit");
    step(0, 16'h0000, 0, 0, 0, "drop_idle");

    // Lone requester is never preempted
    for (int i = 0; i < 40; i++) step(0, 16'h4000, 1, 14, 0, "alone_g14");
    step(0, 16'h4001, 0, 0, 1, "alone_then_contender");
    step(0, 16'h4001, 1, 0, 0, "contender_g0");
    step(0, 16'h0000, 0, 0, 0, "contender_release");

    // Reset mid-grant
    step(0, 16'h0200, 1, 9, 0, "mid_g9_a");
    step(0, 16'h0200, 1, 9, 0, "mid_g9_b");
    step(1, 16'h0201, 0, 0, 0, "mid_reset");
    step(0, 16'h0201, 1, 0, 0, "mid_after_reset_g0");
    step(0, 16'h0000, 0, 0, 0, "mid_release");

    // Random traffic; monitor checks invariants and the waiting bound
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      reset = 1'b0;
      req = req ^ (16'($urandom()) & 16'($urandom()) & 16'($urandom()));
    end
    @(negedge clk);
    req = 16'h0000;
    repeat (3) @(negedge clk);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
